// File: rtl/pcileech_tbx4_bridge_endpoint.sv
// IO-bridge endpoint of the TB x4 link: frames host words onto BUS_DO, buffers BUS_DI results
// in a first-word-fall-through FIFO and qualifies the host link before asserting TB_CONNECT.
module pcileech_tbx4_bridge_endpoint #(
  parameter int unsigned DI_FIFO_DEPTH       = 64,
  parameter int unsigned DI_PROG_FULL_THRESH = 48,
  parameter int unsigned LINK_WAIT           = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             host_link_up,
  input  logic [31:0]                      tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic [63:0]                      rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [40:0]                      BUS_DO,
  output logic                             BUS_DO_CLK,
  input  logic [66:0]                      BUS_DI,
  output logic                             BUS_DI_PROG_FULL,
  output logic                             TB_CONNECT,
  output logic [$clog2(DI_FIFO_DEPTH):0]   rx_level,
  output logic [15:0]                      rx_drop_count
);

  localparam int unsigned PtrW = $clog2(DI_FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(LINK_WAIT + 1);

  typedef enum logic [1:0] {StDisconnected, StQualify, StConnected} link_state_e;

  link_state_e       state_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic              connected_q;
  logic [3:0]        seq_q;
  logic [40:0]       bus_do_q;

  // Link qualification, TX framing and sequence numbering share one registered FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDisconnected;
      wait_cnt_q  <= '0;
      connected_q <= 1'b0;
      seq_q       <= '0;
      bus_do_q    <= '0;
    end else begin
      bus_do_q <= '0;
      if (connected_q && tx_valid) begin
        bus_do_q <= {1'b1, seq_q, 4'h0, tx_data};
        seq_q    <= seq_q + 4'd1;
      end
      unique case (state_q)
        StDisconnected: begin
          if (host_link_up) begin
            state_q    <= StQualify;
            wait_cnt_q <= '0;
          end
        end
        StQualify: begin
          if (!host_link_up) begin
            state_q <= StDisconnected;
          end else if (wait_cnt_q == CntW'(LINK_WAIT - 1)) begin
            state_q     <= StConnected;
            connected_q <= 1'b1;
            seq_q       <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StConnected: begin
          if (!host_link_up) begin
            state_q     <= StDisconnected;
            connected_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StDisconnected;
          connected_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready   = connected_q;
  assign TB_CONNECT = connected_q;
  assign BUS_DO     = bus_do_q;
  assign BUS_DO_CLK = clk;

  logic [63:0]     mem_q [DI_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            prog_full_q;
  logic [15:0]     drop_q;
  logic            di_valid, full, rd_en, wr_en, drop;
  logic            unused_di;

  assign unused_di = ^BUS_DI[65:64];
  assign di_valid  = BUS_DI[66];
  assign full      = (level_q == LvlW'(DI_FIFO_DEPTH));
  assign rx_valid  = (level_q != '0);
  assign rd_en     = rx_valid && rx_ready;
  // A full FIFO still takes a word when the host pops one in the same cycle.
  assign wr_en     = di_valid && connected_q && (!full || rd_en);
  assign drop      = di_valid && !wr_en;

  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + LvlW'(1);
    end else if (!wr_en && rd_en) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= BUS_DI[63:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      prog_full_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q     <= level_d;
      prog_full_q <= (level_q >= LvlW'(DI_PROG_FULL_THRESH));
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign rx_data          = rx_valid ? mem_q[rd_ptr_q] : 64'd0;
  assign rx_level         = level_q;
  assign rx_drop_count    = drop_q;
  assign BUS_DI_PROG_FULL = prog_full_q;

endmodule

// File: tb/tb_pcileech_tbx4_bridge_endpoint.sv
// Directed bench for the TB x4 bridge endpoint: link qualify, TX framing, RX FIFO flow,
// overflow, disconnect and reset mid-stream, with hand-computed expectations.
module tb_pcileech_tbx4_bridge_endpoint;

  localparam int unsigned Depth    = 64;
  localparam int unsigned Thresh   = 48;
  localparam int unsigned LinkWait = 16;

  logic        clk;
  logic        rst;
  logic        host_link_up;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [40:0] bus_do;
  logic        bus_do_clk;
  logic [66:0] bus_di;
  logic        bus_di_prog_full;
  logic        tb_connect;
  logic [6:0]  rx_level;
  logic [15:0] rx_drop_count;

  int n_checks;
  int n_errors;
  int exp_drops;

  pcileech_tbx4_bridge_endpoint #(
    .DI_FIFO_DEPTH      (Depth),
    .DI_PROG_FULL_THRESH(Thresh),
    .LINK_WAIT          (LinkWait)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host_link_up    (host_link_up),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .BUS_DO          (bus_do),
    .BUS_DO_CLK      (bus_do_clk),
    .BUS_DI          (bus_di),
    .BUS_DI_PROG_FULL(bus_di_prog_full),
    .TB_CONNECT      (tb_connect),
    .rx_level        (rx_level),
    .rx_drop_count   (rx_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_bus_do"},    64'(bus_do), 64'd0);
    check_eq({tag, "_prog_full"}, 64'(bus_di_prog_full), 64'd0);
    check_eq({tag, "_connect"},   64'(tb_connect), 64'd0);
    check_eq({tag, "_tx_ready"},  64'(tx_ready), 64'd0);
    check_eq({tag, "_rx_valid"},  64'(rx_valid), 64'd0);
    check_eq({tag, "_rx_data"},   rx_data, 64'd0);
    check_eq({tag, "_rx_level"},  64'(rx_level), 64'd0);
    check_eq({tag, "_drops"},     64'(rx_drop_count), 64'd0);
  endtask

  function automatic logic [66:0] di_word(input logic [63:0] data);
    return {1'b1, 2'b11, data};
  endfunction

  function automatic logic [40:0] do_word(input int seq, input logic [31:0] data);
    logic [3:0] s;
    s = 4'(seq % 16);
    return {1'b1, s, 4'h0, data};
  endfunction

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_drops    = 0;
    rst          = 1'b1;
    host_link_up = 1'b0;
    tx_data      = '0;
    tx_valid     = 1'b0;
    rx_ready     = 1'b0;
    bus_di       = di_word(64'hDEAD);
    tick();
    tick();
    check_reset_values("reset");

    rst    = 1'b0;
    bus_di = di_word(64'h1);
    tick();
    bus_di = di_word(64'h2);
    tick();
    bus_di = '0;
    exp_drops = 2;
    check_eq("drop_disconnected", 64'(rx_drop_count), 64'(exp_drops));
    check_eq("level_disconnected", 64'(rx_level), 64'd0);

    // First qualify attempt aborted after 10 cycles.
    host_link_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq("qualify_abort_conn", 64'(tb_connect), 64'd0);
    end
    host_link_up = 1'b0;
    tick();
    check_eq("qualify_dropped_conn", 64'(tb_connect), 64'd0);
    host_link_up = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check_eq($sformatf("qualify_cycle%0d", k), 64'(tb_connect), 64'(k == 17));
    end
    check_eq("tx_ready_connected", 64'(tx_ready), 64'd1);
    check_eq("bus_do_idle", 64'(bus_do), 64'd0);

    // TX burst with sequence wrap.
    for (int i = 0; i < 20; i++) begin
      tx_data  = 32'h1000 + 32'(i);
      tx_valid = 1'b1;
      tick();
      check_eq($sformatf("tx_word%0d", i), 64'(bus_do), 64'(do_word(i, 32'h1000 + 32'(i))));
    end
    tx_valid = 1'b0;
    tick();
    check_eq("tx_idle_after_burst", 64'(bus_do), 64'd0);

    // RX flow up to the prog-full threshold.
    for (int i = 0; i < 48; i++) begin
      bus_di = di_word(64'hA000_0000_0000_0000 + 64'(i));
      tick();
      if (i == 0) begin
        check_eq("rx_first_valid", 64'(rx_valid), 64'd1);
        check_eq("rx_first_data", rx_data, 64'hA000_0000_0000_0000);
      end
    end
    bus_di = '0;
    check_eq("rx_level_48", 64'(rx_level), 64'd48);
    check_eq("prog_full_not_yet", 64'(bus_di_prog_full), 64'd0);
    tick();
    check_eq("prog_full_rise", 64'(bus_di_prog_full), 64'd1);
    check_eq("rx_head_before_pop", rx_data, 64'hA000_0000_0000_0000);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_eq("rx_level_47", 64'(rx_level), 64'd47);
    check_eq("prog_full_hold", 64'(bus_di_prog_full), 64'd1);
    tick();
    check_eq("prog_full_fall", 64'(bus_di_prog_full), 64'd0);
    rx_ready = 1'b1;
    for (int i = 1; i < 48; i++) begin
      check_eq($sformatf("rx_order%0d", i), rx_data, 64'hA000_0000_0000_0000 + 64'(i));
      tick();
    end
    rx_ready = 1'b0;
    check_eq("rx_empty_valid", 64'(rx_valid), 64'd0);
    check_eq("rx_empty_level", 64'(rx_level), 64'd0);

    // Overflow: 70 writes into 64 entries.
    for (int i = 0; i < 70; i++) begin
      bus_di = di_word(64'hB000 + 64'(i));
      tick();
    end
    bus_di = '0;
    exp_drops += 6;
    check_eq("ovf_level", 64'(rx_level), 64'd64);
    check_eq("ovf_drops", 64'(rx_drop_count), 64'(exp_drops));
    check_eq("ovf_head", rx_data, 64'hB000);
    bus_di   = di_word(64'hC000);
    rx_ready = 1'b1;
    tick();
    bus_di   = '0;
    rx_ready = 1'b0;
    check_eq("full_rw_level", 64'(rx_level), 64'd64);
    check_eq("full_rw_drops", 64'(rx_drop_count), 64'(exp_drops));
    rx_ready = 1'b1;
    for (int i = 1; i < 64; i++) begin
      check_eq($sformatf("ovf_order%0d", i), rx_data, 64'hB000 + 64'(i));
      tick();
    end
    check_eq("ovf_last_word", rx_data, 64'hC000);
    tick();
    rx_ready = 1'b0;
    check_eq("ovf_drained", 64'(rx_level), 64'd0);

    // Disconnect with 10 words buffered.
    for (int i = 0; i < 10; i++) begin
      bus_di = di_word(64'hD000 + 64'(i));
      tick();
    end
    bus_di       = '0;
    host_link_up = 1'b0;
    tick();
    check_eq("disc_connect", 64'(tb_connect), 64'd0);
    check_eq("disc_tx_ready", 64'(tx_ready), 64'd0);
    tx_valid = 1'b1;
    tx_data  = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      bus_di = di_word(64'hE000 + 64'(i));
      tick();
      check_eq("disc_bus_do", 64'(bus_do), 64'd0);
    end
    bus_di   = '0;
    tx_valid = 1'b0;
    exp_drops += 3;
    check_eq("disc_drops", 64'(rx_drop_count), 64'(exp_drops));
    check_eq("disc_level", 64'(rx_level), 64'd10);
    rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("disc_drain%0d", i), rx_data, 64'hD000 + 64'(i));
      tick();
    end
    rx_ready = 1'b0;
    check_eq("disc_drained", 64'(rx_valid), 64'd0);
    host_link_up = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
    end
    check_eq("reconnect", 64'(tb_connect), 64'd1);
    tx_data  = 32'h5555;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check_eq("reconnect_seq0", 64'(bus_do), 64'(do_word(0, 32'h5555)));

    // Reset mid-stream with 5 buffered words and a TX burst running.
    for (int i = 0; i < 5; i++) begin
      bus_di = di_word(64'hF000 + 64'(i));
      tick();
    end
    check_eq("pre_rst_level", 64'(rx_level), 64'd5);
    tx_valid = 1'b1;
    tx_data  = 32'h7001;
    tick();
    tx_data  = 32'h7002;
    rst      = 1'b1;
    tick();
    check_reset_values("midrst");
    rst      = 1'b0;
    tx_valid = 1'b0;
    bus_di   = '0;
    tick();
    check_eq("post_rst_connect", 64'(tb_connect), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
